// File: rtl/ew_op_pipe.sv
// Element-wise residual operator: joins shortcut (s0) and main (s1) lanes through
// align, op and round/saturate/relu stages, with start/done job framing and last tagging.
module ew_op_pipe #(
  parameter int LANES   = 32,
  parameter int DAT_DW  = 8,
  parameter int SC_DW   = 16,
  parameter int ACC_DW  = 32,
  parameter int SCALE_W = 5,
  parameter int LEN_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic [SCALE_W-1:0]        short_cut_scale,
  input  logic [SCALE_W-1:0]        main_dat_scale,
  input  logic [SCALE_W-1:0]        res_add_shift,
  input  logic [1:0]                ew_op_mode,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      done,
  input  logic                      s0_dat_vld,
  output logic                      s0_dat_rdy,
  input  logic [LANES*SC_DW-1:0]    s0_dat_pd,
  input  logic                      s1_dat_vld,
  output logic                      s1_dat_rdy,
  input  logic [LANES*DAT_DW-1:0]   s1_dat_pd,
  output logic                      dat_out_vld,
  output logic [LANES*DAT_DW-1:0]   dat_out_pd,
  output logic                      dat_out_last,
  input  logic                      dat_out_rdy
);

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpMul = 2'd1,
    OpSub = 2'd2,
    OpMax = 2'd3
  } opMode_e;

  localparam logic signed [ACC_DW-1:0] AccMax = {1'b0, {(ACC_DW-1){1'b1}}};
  localparam logic signed [ACC_DW-1:0] AccOne = {{(ACC_DW-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_DW-1:0] DatMax = {{(ACC_DW-DAT_DW+1){1'b0}}, {(DAT_DW-1){1'b1}}};
  localparam logic signed [ACC_DW-1:0] DatMin = {{(ACC_DW-DAT_DW+1){1'b1}}, {(DAT_DW-1){1'b0}}};

  logic                busyQ, busyD;
  logic                doneQ, doneD;
  logic [LEN_W-1:0]    inCntQ, inCntD;
  logic [LEN_W-1:0]    outCntQ, outCntD;
  logic [LEN_W-1:0]    cfgLenQ, cfgLenD;
  opMode_e             cfgModeQ, cfgModeD;
  logic [SCALE_W-1:0]  cfgScScaleQ, cfgScScaleD;
  logic [SCALE_W-1:0]  cfgMdScaleQ, cfgMdScaleD;
  logic [SCALE_W-1:0]  cfgShiftQ, cfgShiftD;
  logic                cfgReluQ, cfgReluD;

  logic                vld1Q, vld1D;
  logic                vld2Q, vld2D;
  logic                vld3Q, vld3D;

  logic signed [ACC_DW-1:0] aQ [LANES];
  logic signed [ACC_DW-1:0] bQ [LANES];
  logic signed [ACC_DW-1:0] aD [LANES];
  logic signed [ACC_DW-1:0] bD [LANES];
  logic signed [ACC_DW-1:0] tQ [LANES];
  logic signed [ACC_DW-1:0] tD [LANES];
  logic [LANES*DAT_DW-1:0]  pdQ, pdD;

  logic outFire;
  logic st1Can, st2Can, st3Can;
  logic lastBeat;
  logic accept;

  // Each stage loads when empty or when its successor is taking its data this cycle.
  assign outFire  = vld3Q & dat_out_rdy;
  assign st3Can   = ~vld3Q | dat_out_rdy;
  assign st2Can   = ~vld2Q | st3Can;
  assign st1Can   = ~vld1Q | st2Can;
  assign lastBeat = (outCntQ == (cfgLenQ - 1'b1));
  assign accept   = busyQ & s0_dat_vld & s1_dat_vld & st1Can & (inCntQ < cfgLenQ);

  assign s0_dat_rdy   = accept;
  assign s1_dat_rdy   = accept;
  assign dat_out_vld  = vld3Q;
  assign dat_out_pd   = pdQ;
  assign dat_out_last = vld3Q & lastBeat;
  assign busy         = busyQ;
  assign done         = doneQ;

  always_comb begin
    busyD       = busyQ;
    doneD       = 1'b0;
    inCntD      = inCntQ;
    outCntD     = outCntQ;
    cfgLenD     = cfgLenQ;
    cfgModeD    = cfgModeQ;
    cfgScScaleD = cfgScScaleQ;
    cfgMdScaleD = cfgMdScaleQ;
    cfgShiftD   = cfgShiftQ;
    cfgReluD    = cfgReluQ;
    vld1D       = st1Can ? accept : vld1Q;
    vld2D       = st2Can ? vld1Q  : vld2Q;
    vld3D       = st3Can ? vld2Q  : vld3Q;
    if (!busyQ) begin
      if (start) begin
        busyD       = 1'b1;
        inCntD      = '0;
        outCntD     = '0;
        cfgLenD     = len;
        cfgModeD    = opMode_e'(ew_op_mode);
        cfgScScaleD = short_cut_scale;
        cfgMdScaleD = main_dat_scale;
        cfgShiftD   = res_add_shift;
        cfgReluD    = relu_en;
      end
    end else begin
      if (accept) inCntD = inCntQ + 1'b1;
      if (outFire) outCntD = outCntQ + 1'b1;
      // A zero-length job still spends one busy cycle before reporting done.
      if ((outFire && lastBeat) || (cfgLenQ == '0)) begin
        busyD = 1'b0;
        doneD = 1'b1;
      end
    end
  end

  // Align: sign-extend both lanes, then apply the per-stream pre-shift (none for multiply).
  always_comb begin
    logic signed [ACC_DW-1:0] s0Ext;
    logic signed [ACC_DW-1:0] s1Ext;
    for (int i = 0; i < LANES; i++) begin
      s0Ext = {{(ACC_DW-SC_DW){s0_dat_pd[SC_DW*i+SC_DW-1]}}, s0_dat_pd[SC_DW*i +: SC_DW]};
      s1Ext = {{(ACC_DW-DAT_DW){s1_dat_pd[DAT_DW*i+DAT_DW-1]}}, s1_dat_pd[DAT_DW*i +: DAT_DW]};
      if (cfgModeQ == OpMul) begin
        aD[i] = s0Ext;
        bD[i] = s1Ext;
      end else begin
        aD[i] = s0Ext <<< cfgScScaleQ;
        bD[i] = s1Ext <<< cfgMdScaleQ;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      tD[i] = aQ[i] + bQ[i];
      case (cfgModeQ)
        OpAdd: tD[i] = aQ[i] + bQ[i];
        OpMul: tD[i] = aQ[i] * bQ[i];
        OpSub: tD[i] = aQ[i] - bQ[i];
        OpMax: tD[i] = (aQ[i] > bQ[i]) ? aQ[i] : bQ[i];
        default: tD[i] = aQ[i] + bQ[i];
      endcase
    end
  end

  // Round half up on the dropped bits, but never push the positive maximum past itself.
  always_comb begin
    logic signed [ACC_DW-1:0] q;
    logic signed [ACC_DW-1:0] r;
    logic                     roundBit;
    logic [DAT_DW-1:0]        lane;
    pdD = '0;
    for (int i = 0; i < LANES; i++) begin
      q        = tQ[i] >>> cfgShiftQ;
      roundBit = (cfgShiftQ != '0) && tQ[i][cfgShiftQ - 1'b1];
      r        = (roundBit && (q != AccMax)) ? (q + AccOne) : q;
      if (r > DatMax) begin
        lane = DatMax[DAT_DW-1:0];
      end else if (r < DatMin) begin
        lane = DatMin[DAT_DW-1:0];
      end else begin
        lane = r[DAT_DW-1:0];
      end
      if (cfgReluQ && lane[DAT_DW-1]) lane = '0;
      pdD[DAT_DW*i +: DAT_DW] = lane;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busyQ       <= 1'b0;
      doneQ       <= 1'b0;
      inCntQ      <= '0;
      outCntQ     <= '0;
      cfgLenQ     <= '0;
      cfgModeQ    <= OpAdd;
      cfgScScaleQ <= '0;
      cfgMdScaleQ <= '0;
      cfgShiftQ   <= '0;
      cfgReluQ    <= 1'b0;
      vld1Q       <= 1'b0;
      vld2Q       <= 1'b0;
      vld3Q       <= 1'b0;
      pdQ         <= '0;
      for (int i = 0; i < LANES; i++) begin
        aQ[i] <= '0;
        bQ[i] <= '0;
        tQ[i] <= '0;
      end
    end else begin
      busyQ       <= busyD;
      doneQ       <= doneD;
      inCntQ      <= inCntD;
      outCntQ     <= outCntD;
      cfgLenQ     <= cfgLenD;
      cfgModeQ    <= cfgModeD;
      cfgScScaleQ <= cfgScScaleD;
      cfgMdScaleQ <= cfgMdScaleD;
      cfgShiftQ   <= cfgShiftD;
      cfgReluQ    <= cfgReluD;
      vld1Q       <= vld1D;
      vld2Q       <= vld2D;
      vld3Q       <= vld3D;
      if (st3Can && vld2Q) pdQ <= pdD;
      for (int i = 0; i < LANES; i++) begin
        if (st1Can && accept) begin
          aQ[i] <= aD[i];
          bQ[i] <= bD[i];
        end
        if (st2Can && vld1Q) tQ[i] <= tD[i];
      end
    end
  end

endmodule

// File: tb/tb_ew_op_pipe.sv
// Self-checking bench for ew_op_pipe: spec vector table, directed control corners,
// and randomized backpressured jobs compared against an arithmetic reference model.
module tb_ew_op_pipe;

  localparam int LANES   = 32;
  localparam int DAT_DW  = 8;
  localparam int SC_DW   = 16;
  localparam int ACC_DW  = 32;
  localparam int SCALE_W = 5;
  localparam int LEN_W   = 16;
  localparam int LIMIT   = 4000;

  typedef logic [LANES*SC_DW-1:0]  scBeat_t;
  typedef logic [LANES*DAT_DW-1:0] outBeat_t;
  typedef struct {
    logic [1:0] mode;
    int         scS;
    int         mdS;
    int         sh;
    logic       relu;
  } cfg_t;
  typedef struct {
    cfg_t cfg;
    int   s0;
    int   s1;
    int   expVal;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [LEN_W-1:0]       len;
  logic [SCALE_W-1:0]     short_cut_scale, main_dat_scale, res_add_shift;
  logic [1:0]             ew_op_mode;
  logic                   relu_en;
  logic                   busy, done;
  logic                   s0_dat_vld, s0_dat_rdy;
  scBeat_t                s0_dat_pd;
  logic                   s1_dat_vld, s1_dat_rdy;
  outBeat_t               s1_dat_pd;
  logic                   dat_out_vld, dat_out_last, dat_out_rdy;
  outBeat_t               dat_out_pd;

  scBeat_t  s0Q[$];
  outBeat_t s1Q[$];
  outBeat_t expQ[$];

  int checks = 0;
  int failures = 0;
  int sepErr, lastErr, stallErr, earlyDone, lastCnt;

  always #5 clk = ~clk;

  ew_op_pipe #(
    .LANES(LANES), .DAT_DW(DAT_DW), .SC_DW(SC_DW), .ACC_DW(ACC_DW),
    .SCALE_W(SCALE_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .short_cut_scale(short_cut_scale), .main_dat_scale(main_dat_scale),
    .res_add_shift(res_add_shift), .ew_op_mode(ew_op_mode), .relu_en(relu_en),
    .busy(busy), .done(done),
    .s0_dat_vld(s0_dat_vld), .s0_dat_rdy(s0_dat_rdy), .s0_dat_pd(s0_dat_pd),
    .s1_dat_vld(s1_dat_vld), .s1_dat_rdy(s1_dat_rdy), .s1_dat_pd(s1_dat_pd),
    .dat_out_vld(dat_out_vld), .dat_out_pd(dat_out_pd),
    .dat_out_last(dat_out_last), .dat_out_rdy(dat_out_rdy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic checkBeat(input string name, input outBeat_t act, input outBeat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic cfg_t mkCfg(input int mode, input int scS, input int mdS, input int sh, input int relu);
    cfg_t c;
    c.mode = 2'(mode);
    c.scS  = scS;
    c.mdS  = mdS;
    c.sh   = sh;
    c.relu = 1'(relu);
    return c;
  endfunction

  function automatic vec_t mkVec(input cfg_t c, input int s0, input int s1, input int e);
    vec_t v;
    v.cfg = c;
    v.s0 = s0;
    v.s1 = s1;
    v.expVal = e;
    return v;
  endfunction

  // Reference: plain integer arithmetic, rounding written as floor((t + 2^(sh-1)) / 2^sh).
  function automatic int refElem(input cfg_t c, input int s0, input int s1);
    longint a, b, t, n, p, q;
    int r;
    if (c.mode == 2'd1) begin
      a = s0;
      b = s1;
    end else begin
      a = longint'(s0) * (longint'(1) << c.scS);
      b = longint'(s1) * (longint'(1) << c.mdS);
    end
    a = longint'(int'(a));
    b = longint'(int'(b));
    case (c.mode)
      2'd0: t = a + b;
      2'd1: t = a * b;
      2'd2: t = a - b;
      default: t = (a > b) ? a : b;
    endcase
    t = longint'(int'(t));
    if (c.sh == 0) begin
      q = t;
    end else begin
      p = longint'(1) << c.sh;
      n = t + p / 2;
      q = n / p;
      if ((n % p != 0) && (n < 0)) q = q - 1;
    end
    if (q > 127) r = 127;
    else if (q < -128) r = -128;
    else r = int'(q);
    if (c.relu && r < 0) r = 0;
    return r;
  endfunction

  function automatic scBeat_t uniS0(input int v);
    scBeat_t b;
    for (int i = 0; i < LANES; i++) b[SC_DW*i +: SC_DW] = SC_DW'(v);
    return b;
  endfunction

  function automatic outBeat_t uniOut(input int v);
    outBeat_t b;
    for (int i = 0; i < LANES; i++) b[DAT_DW*i +: DAT_DW] = DAT_DW'(v);
    return b;
  endfunction

  task automatic clearQ();
    s0Q.delete();
    s1Q.delete();
    expQ.delete();
  endtask

  task automatic pushUniform(input int v0, input int v1, input int e);
    s0Q.push_back(uniS0(v0));
    s1Q.push_back(uniOut(v1));
    expQ.push_back(uniOut(e));
  endtask

  task automatic pushRandom(input cfg_t c);
    scBeat_t b0;
    outBeat_t b1, be;
    int v0, v1;
    for (int i = 0; i < LANES; i++) begin
      v0 = int'($urandom_range(0, 65535)) - 32768;
      v1 = int'($urandom_range(0, 255)) - 128;
      b0[SC_DW*i +: SC_DW]   = SC_DW'(v0);
      b1[DAT_DW*i +: DAT_DW] = DAT_DW'(v1);
      be[DAT_DW*i +: DAT_DW] = DAT_DW'(refElem(c, v0, v1));
    end
    s0Q.push_back(b0);
    s1Q.push_back(b1);
    expQ.push_back(be);
  endtask

  function automatic cfg_t randCfg();
    return mkCfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 1)));
  endfunction

  task automatic startJob(input cfg_t c, input int n);
    ew_op_mode      = c.mode;
    short_cut_scale = SCALE_W'(c.scS);
    main_dat_scale  = SCALE_W'(c.mdS);
    res_add_shift   = SCALE_W'(c.sh);
    relu_en         = c.relu;
    len             = LEN_W'(n);
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input bit rv);
    int idx = 0;
    int cyc = 0;
    bit fired;
    if (n > 0) begin
      s0_dat_pd  = s0Q[0];
      s1_dat_pd  = s1Q[0];
      s0_dat_vld = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      s1_dat_vld = rv ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    while (idx < n && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      fired = s0_dat_rdy && s1_dat_rdy;
      if (s0_dat_rdy !== s1_dat_rdy) sepErr++;
      @(posedge clk); #1;
      if (fired) begin
        idx++;
        if (idx < n) begin
          s0_dat_pd  = s0Q[idx];
          s1_dat_pd  = s1Q[idx];
          s0_dat_vld = rv ? 1'($urandom_range(0, 1)) : 1'b1;
          s1_dat_vld = rv ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
          s0_dat_vld = 1'b0;
          s1_dat_vld = 1'b0;
        end
      end else if (rv) begin
        if (!s0_dat_vld) s0_dat_vld = 1'($urandom_range(0, 1));
        if (!s1_dat_vld) s1_dat_vld = 1'($urandom_range(0, 1));
      end
    end
    if (idx < n) checkOutput("stim_timeout_beats", 32'(idx), 32'(n));
  endtask

  task automatic collectOutputs(input int n, input bit rr);
    int k = 0;
    int cyc = 0;
    bit prevStall = 1'b0;
    outBeat_t prevPd = '0;
    dat_out_rdy = rr ? 1'($urandom_range(0, 1)) : 1'b1;
    while (k < n && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (prevStall && (dat_out_vld !== 1'b1 || dat_out_pd !== prevPd)) stallErr++;
      if (done) earlyDone++;
      if (dat_out_vld && dat_out_rdy) begin
        checkBeat($sformatf("beat%0d", k), dat_out_pd, expQ[k]);
        if (dat_out_last) lastCnt++;
        if (dat_out_last !== (k == n - 1)) lastErr++;
        k++;
        prevStall = 1'b0;
      end else begin
        prevStall = dat_out_vld;
      end
      prevPd = dat_out_pd;
      @(posedge clk); #1;
      dat_out_rdy = rr ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (k < n) checkOutput("out_timeout_beats", 32'(k), 32'(n));
    dat_out_rdy = 1'b1;
    @(negedge clk);
    checkOutput("done_after_last", 32'(done), 32'd1);
    checkOutput("busy_clear_at_done", 32'(busy), 32'd0);
    checkOutput("no_extra_output", 32'(dat_out_vld), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic runBeats(input int n, input bit rv, input bit rr);
    sepErr = 0; lastErr = 0; stallErr = 0; earlyDone = 0; lastCnt = 0;
    fork
      applyStimulus(n, rv);
      collectOutputs(n, rr);
    join
    checkOutput("streams_joined", 32'(sepErr), 32'd0);
    checkOutput("single_last", 32'(lastCnt), 32'd1);
    checkOutput("last_position", 32'(lastErr), 32'd0);
    checkOutput("hold_under_backpressure", 32'(stallErr), 32'd0);
    checkOutput("no_early_done", 32'(earlyDone), 32'd0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t vecs[13];
    cfg_t c;
    int lat, busyCyc, doneCnt, rdyCnt, badAfter;

    vecs[0]  = mkVec(mkCfg(0, 1, 0, 1, 0), 100, -20, 90);
    vecs[1]  = mkVec(mkCfg(0, 1, 0, 0, 0), 127, 127, 127);
    vecs[2]  = mkVec(mkCfg(2, 0, 0, 0, 0), 10, 30, -20);
    vecs[3]  = mkVec(mkCfg(2, 0, 0, 0, 1), 10, 30, 0);
    vecs[4]  = mkVec(mkCfg(2, 0, 0, 1, 0), 0, 3, -1);
    vecs[5]  = mkVec(mkCfg(1, 0, 0, 8, 0), -300, 100, -117);
    vecs[6]  = mkVec(mkCfg(1, 0, 0, 0, 0), 32767, 127, 127);
    vecs[7]  = mkVec(mkCfg(3, 0, 0, 0, 0), -5, 3, 3);
    vecs[8]  = mkVec(mkCfg(3, 0, 2, 0, 0), -5, 3, 12);
    vecs[9]  = mkVec(mkCfg(2, 0, 0, 0, 0), -1000, 100, -128);
    vecs[10] = mkVec(mkCfg(1, 3, 3, 0, 0), -2, -3, 6);
    vecs[11] = mkVec(mkCfg(0, 0, 0, 2, 0), -6, 0, -1);
    vecs[12] = mkVec(mkCfg(3, 1, 0, 0, 1), -50, -60, 0);

    rst_n = 1'b0; start = 1'b0; len = '0;
    short_cut_scale = '0; main_dat_scale = '0; res_add_shift = '0;
    ew_op_mode = 2'd0; relu_en = 1'b0;
    s0_dat_vld = 1'b1; s1_dat_vld = 1'b1; s0_dat_pd = '0; s1_dat_pd = '0;
    dat_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_out_vld", 32'(dat_out_vld), 32'd0);
    checkOutput("reset_out_last", 32'(dat_out_last), 32'd0);
    checkOutput("reset_rdy", 32'({s0_dat_rdy, s1_dat_rdy}), 32'd0);
    checkBeat("reset_out_pd", dat_out_pd, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; s0_dat_vld = 1'b0; s1_dat_vld = 1'b0;
    @(posedge clk); #1;

    $display("[TB] latency and done timing");
    startJob(mkCfg(0, 1, 0, 1, 0), 1);
    s0_dat_pd = uniS0(100); s1_dat_pd = uniOut(-20);
    s0_dat_vld = 1'b1; s1_dat_vld = 1'b1;
    @(negedge clk);
    checkOutput("first_accept", 32'(s0_dat_rdy), 32'd1);
    @(posedge clk); #1;
    s0_dat_vld = 1'b0; s1_dat_vld = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dat_out_vld && lat < 10);
    checkOutput("latency_cycles", 32'(lat), 32'd3);
    checkBeat("latency_beat", dat_out_pd, uniOut(90));
    checkOutput("latency_last", 32'(dat_out_last), 32'd1);
    @(negedge clk);
    checkOutput("latency_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    $display("[TB] vector table");
    for (int v = 0; v < 13; v++) begin
      clearQ();
      pushUniform(vecs[v].s0, vecs[v].s1, vecs[v].expVal);
      startJob(vecs[v].cfg, 1);
      runBeats(1, 1'b0, 1'b0);
    end

    $display("[TB] add job of four beats");
    clearQ();
    pushUniform(100, -20, 90);
    pushUniform(127, 127, 127);
    pushUniform(-100, 20, -90);
    pushUniform(1, 0, 1);
    startJob(mkCfg(0, 1, 0, 1, 0), 4);
    runBeats(4, 1'b0, 1'b0);

    $display("[TB] randomized backpressure jobs");
    for (int j = 0; j < 2; j++) begin
      c = randCfg();
      clearQ();
      for (int b = 0; b < 100; b++) pushRandom(c);
      startJob(c, 100);
      runBeats(100, 1'b1, 1'b1);
    end

    $display("[TB] zero-length job");
    s0_dat_vld = 1'b1; s1_dat_vld = 1'b1;
    startJob(mkCfg(0, 0, 0, 0, 0), 0);
    busyCyc = 0; doneCnt = 0; rdyCnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) busyCyc++;
      if (done) doneCnt++;
      if (s0_dat_rdy || s1_dat_rdy) rdyCnt++;
      @(posedge clk); #1;
    end
    s0_dat_vld = 1'b0; s1_dat_vld = 1'b0;
    checkOutput("len0_busy_cycles", 32'(busyCyc), 32'd1);
    checkOutput("len0_done_pulses", 32'(doneCnt), 32'd1);
    checkOutput("len0_no_accept", 32'(rdyCnt), 32'd0);

    $display("[TB] start while busy");
    clearQ();
    pushUniform(5, 6, 11);
    pushUniform(-7, 2, -5);
    startJob(mkCfg(0, 0, 0, 0, 0), 2);
    startJob(mkCfg(1, 2, 2, 3, 1), 5);
    checkOutput("busy_after_ignored_start", 32'(busy), 32'd1);
    runBeats(2, 1'b0, 1'b0);

    $display("[TB] reset mid-job");
    s0_dat_pd = uniS0(3); s1_dat_pd = uniOut(4);
    s0_dat_vld = 1'b1; s1_dat_vld = 1'b1; dat_out_rdy = 1'b0;
    startJob(mkCfg(0, 0, 0, 0, 0), 10);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("prereset_out_vld", 32'(dat_out_vld), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_out_vld", 32'(dat_out_vld), 32'd0);
    checkOutput("midreset_out_last", 32'(dat_out_last), 32'd0);
    checkOutput("midreset_rdy", 32'({s0_dat_rdy, s1_dat_rdy}), 32'd0);
    checkBeat("midreset_out_pd", dat_out_pd, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; s0_dat_vld = 1'b0; s1_dat_vld = 1'b0; dat_out_rdy = 1'b1;
    badAfter = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || dat_out_vld || busy) badAfter++;
      @(posedge clk); #1;
    end
    checkOutput("no_done_after_reset", 32'(badAfter), 32'd0);
    c = randCfg();
    clearQ();
    for (int b = 0; b < 3; b++) pushRandom(c);
    startJob(c, 3);
    runBeats(3, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ew_op_pipe.md
# ew_op_pipe

Parametrised, pipelined element-wise operator for the CONV residual path. It joins the shortcut stream (s0, BN-width) and the main-data stream (s1, data-width) lane by lane. It supports add, subtract, multiply and max, followed by a rounding right-shift, signed saturation and optional ReLU. Each job covers a programmed number of beats and is framed by start/done, with a last flag on the final output beat. The block replaces the fixed add-only residual adder and sits between the BN/shortcut fetch and the CONV writeback.

## Interface
- LANES, 32, elements per beat (Tout)
- DAT_DW, 8, s1 and output element width, signed
- SC_DW, 16, s0 element width, signed
- ACC_DW, 32, internal arithmetic width; must be ≥ SC_DW+DAT_DW+1
- SCALE_W, 5, width of shift fields
- LEN_W, 16, beat-count width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; latches config and len; ignored while busy
- len  in  LEN_W  beats in the job
- short_cut_scale, main_dat_scale, res_add_shift  in  SCALE_W  shift amounts
- ew_op_mode  in  2  0 add, 1 mul, 2 sub (s0−s1), 3 max
- relu_en  in  1  clamp negative results to 0
- busy  out  1  job active
- done  out  1  one-cycle pulse at job end
- s0_dat_vld / s0_dat_rdy  in/out  1  shortcut handshake
- s0_dat_pd  in  LANES*SC_DW  shortcut lanes, lane i at [SC_DW*i +: SC_DW]
- s1_dat_vld / s1_dat_rdy  in/out  1  main-data handshake
- s1_dat_pd  in  LANES*DAT_DW  main lanes
- dat_out_vld  out  1  output valid
- dat_out_pd  out  LANES*DAT_DW  result lanes
- dat_out_last  out  1  marks the final beat of the job
- dat_out_rdy  in  1  downstream ready

## Operation
- Idle: busy=0. On start, the block latches mode, scales, relu_en and len into a cfg register; busy←1. Input port values are don't-care during the job.
- Join: a beat is accepted when busy & s0_dat_vld & s1_dat_vld & stage-1 can accept & in_cnt<len. Both s0_dat_rdy and s1_dat_rdy assert only in that cycle, so the two streams are never consumed independently.
- Stage 1, align (per lane), computed at ACC_DW with sign extension:
  - a = s0<<<short_cut_scale
  - b = s1<<<main_dat_scale
  - In mul mode no pre-shift is applied: a=s0, b=s1.
  - Software guarantees shifts do not overflow ACC_DW; overflow wraps.
- Stage 2, op:
  - add a+b
  - sub a−b
  - mul a*b, full product truncated to ACC_DW
  - max signed max(a,b)
- Stage 3, round/saturate/relu:
  - If res_add_shift=0, r=t.
  - Otherwise r=(t>>>sh)+t[sh−1] (round half up), except that no increment is applied when t>>>sh equals the ACC_DW positive maximum.
  - Saturate r to the signed DAT_DW range [−2^(DAT_DW−1), 2^(DAT_DW−1)−1].
  - If relu_en and the result is negative, output 0.
- Counters: in_cnt counts accepted beats; out_cnt counts output handshakes. dat_out_last = dat_out_vld & (out_cnt==len−1).
- Completion: on the output handshake with last, busy←0 and done pulses in the next cycle. A new start is accepted in that done cycle.
- len=0: busy is asserted for one cycle, no beats are accepted, and done pulses on the cycle after start.
- start while busy: ignored, cfg unchanged.

## Timing
- Reset values: all stage valids 0, busy 0, done 0, dat_out_vld 0, dat_out_last 0, s0/s1_dat_rdy 0, counters 0. dat_out_pd resets to 0.
- Reset mid-job drops all in-flight beats, with no done pulse.
- Three registered stages; latency is 3 cycles from input handshake to dat_out_vld (cycle N accept → dat_out_vld high in cycle N+3).
- Per-stage valid/ready: stage k loads when it is empty or stage k+1 takes its data. With dat_out_rdy held high, throughput is 1 beat/cycle. Bubbles collapse.
- While dat_out_rdy=0, dat_out_pd, dat_out_vld and dat_out_last are held stable.
- No combinational path from s*_dat_vld to s*_dat_rdy other than the join AND. No combinational path from dat_out_rdy to dat_out_vld.

## Test plan
- Add, LANES=32, scales 1/0, shift 1, relu 0, len 4:
  - s0 lane=100, s1 lane=−20 → (200−20)>>1=90.
  - s0=127, s1=127, shift 0 → 381 saturates to 127.
  - Expect done 1 cycle after the 4th output.
- Sub and relu: s0=10, s1=30, mode 2 → −20 with relu 0; 0 with relu 1.
  - Rounding: t=−3, shift 1 → −1 (−2+1).
- Mul: s0=−300, s1=100, shift 8 → −30000>>8 = −118 (rounded −117.19 → −117), within the valid range so no saturation.
  - s0=32767, s1=127, shift 0 → saturates to 127.
- Max: s0=−5, s1=3, scales 0 → 3. Repeat with main_dat_scale 2 → 12.
- Backpressure: random s0/s1 vld skew plus dat_out_rdy toggled 50%, len 100.
  - Exactly 100 outputs, in order, checked against the reference model.
  - Single last on beat 99, no beat lost or duplicated.
  - Streams never consumed separately.
- Control corners:
  - len=0 → done with no beats.
  - start while busy → ignored.
  - rst_n low mid-job → all outputs reach reset values next cycle; a new job afterwards runs clean.
